// File: rtl/event_blinker.sv
// Stretches 1-cycle game events into fixed-length LED flashes.
// Events that arrive during a flash are queued in a saturating counter and replayed in order.
//
//   state  | meaning
//   S_IDLE | LED dark; launches a flash when pending != 0
//   S_ON   | LED lit for ON_TICKS ticks
//   S_OFF  | forced dark gap for OFF_TICKS ticks
module event_blinker #(
  parameter int CLK_DIV   = 50000,
  parameter int ON_TICKS  = 200,
  parameter int OFF_TICKS = 100,
  parameter int PEND_W    = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              event_i,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TMAX   = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TCK_W  = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [TCK_W-1:0]   tcnt_q, tcnt_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic               led_q, led_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic               tick;
  logic               launch;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      tcnt_q  <= '0;
      pend_q  <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tcnt_d  = tcnt_q;
    launch  = 1'b0;
    tick    = (presc_q == PRE_W'(CLK_DIV - 1));

    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        tcnt_d  = '0;
        if (pend_q != '0) begin
          launch  = 1'b1;
          state_d = S_ON;
        end
      end
      S_ON: begin
        presc_d = tick ? '0 : presc_q + PRE_W'(1);
        if (tick) begin
          if (tcnt_q == TCK_W'(ON_TICKS - 1)) begin
            tcnt_d  = '0;
            state_d = S_OFF;
          end else begin
            tcnt_d = tcnt_q + TCK_W'(1);
          end
        end
      end
      S_OFF: begin
        presc_d = tick ? '0 : presc_q + PRE_W'(1);
        if (tick) begin
          if (tcnt_q == TCK_W'(OFF_TICKS - 1)) begin
            tcnt_d  = '0;
            state_d = S_IDLE;
          end else begin
            tcnt_d = tcnt_q + TCK_W'(1);
          end
        end
      end
      default: begin
        presc_d = '0;
        tcnt_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // An event and a launch in the same cycle cancel out; a dropped event is flagged, never wrapped.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = 1'b0;
    if (event_i && !launch) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (!event_i && launch) begin
      pend_d = pend_q - PEND_W'(1);
    end
    led_d  = (state_d == S_ON);
    busy_d = (state_d != S_IDLE) || (pend_d != '0);
  end

  assign led      = led_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule
